// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the write-port arbiter slice.
// No logic lives here.
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_ADDR = 5'd0;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after i_ptr wins.
// Zero latency, no state; the caller owns the pointer and masks requests for back-pressure.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);

  logic [PW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = PW'((int'(i_ptr) + i) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin share of the single RF write port; accept at edge N, RF written at edge N+1.
// i_hold blocks new grants while the staged write still drains; the RF never back-pressures.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [RF_AW*NREQ-1:0] i_req_addr,
  input  logic [RF_DW*NREQ-1:0] i_req_data,
  input  logic                  i_hold,
  output logic                  o_rd_wen,
  output logic [RF_AW-1:0]      o_rd_waddr,
  output logic [RF_DW-1:0]      o_rd_wdata,
  input  logic [RF_AW-1:0]      i_rs1_raddr,
  input  logic [RF_AW-1:0]      i_rs2_raddr,
  output logic                  o_rs1_pend,
  output logic                  o_rs2_pend,
  output logic                  o_busy
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_xfer;
  wr_req_t          w_sel;

  logic [PW-1:0]    r_ptr;
  logic             r_wen;
  logic [RF_AW-1:0] r_waddr;
  logic [RF_DW-1:0] r_wdata;

  assign w_elig = i_req_valid & {NREQ{!i_hold}};

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // Grants are only ever issued to valid requesters, so any grant is a transfer.
  assign w_xfer      = |w_gnt;
  assign o_req_ready = w_gnt;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        w_sel.addr = i_req_addr[RF_AW*k +: RF_AW];
        w_sel.data = i_req_data[RF_DW*k +: RF_DW];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_xfer) begin
      r_ptr   <= (w_idx == PW'(NREQ-1)) ? '0 : w_idx + PW'(1);
      // x0 writes complete the handshake but never reach the RF.
      r_wen   <= (w_sel.addr != RF_ZERO_ADDR);
      r_waddr <= w_sel.addr;
      r_wdata <= w_sel.data;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign o_rd_wen   = r_wen;
  assign o_rd_waddr = r_waddr;
  assign o_rd_wdata = r_wdata;
  assign o_busy     = r_wen;

  assign o_rs1_pend = r_wen && (i_rs1_raddr == r_waddr) && (i_rs1_raddr != RF_ZERO_ADDR);
  assign o_rs2_pend = r_wen && (i_rs2_raddr == r_waddr) && (i_rs2_raddr != RF_ZERO_ADDR);

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed vector bench for rf_wr_arbiter with NREQ=2.
module tb_rf_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        hold;
  logic        rd_wen;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic [4:0]  rs1_raddr;
  logic [4:0]  rs2_raddr;
  logic        rs1_pend;
  logic        rs2_pend;
  logic        busy;

  int checks;
  int failures;

  rf_wr_arbiter #(.NREQ(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .i_hold      (hold),
    .o_rd_wen    (rd_wen),
    .o_rd_waddr  (rd_waddr),
    .o_rd_wdata  (rd_wdata),
    .i_rs1_raddr (rs1_raddr),
    .i_rs2_raddr (rs2_raddr),
    .o_rs1_pend  (rs1_pend),
    .o_rs2_pend  (rs2_pend),
    .o_busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  vld;
    logic        hld;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  e_rdy;
    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_p1;
    logic        e_p2;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic [1:0] vld, input logic hld,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [1:0] e_rdy, input logic e_wen,
                              input logic [4:0] e_waddr, input logic [31:0] e_wdata,
                              input logic e_p1, input logic e_p2);
    vec_t v;
    v.vld = vld; v.hld = hld; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.rs1 = rs1; v.rs2 = rs2; v.e_rdy = e_rdy; v.e_wen = e_wen;
    v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_p1 = e_p1; v.e_p2 = e_p2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_stage(input string tag, input logic e_wen, input logic [4:0] e_waddr,
                           input logic [31:0] e_wdata);
    chk({tag, "_wen"},   32'(rd_wen),   32'(e_wen));
    chk({tag, "_waddr"}, 32'(rd_waddr), 32'(e_waddr));
    chk({tag, "_wdata"}, rd_wdata,      e_wdata);
    chk({tag, "_busy"},  32'(busy),     32'(e_wen));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {32'h22, 32'h11};
    rs1_raddr = 5'd0;
    rs2_raddr = 5'd0;

    // Vectors run back to back from the post-reset state; each row's stage
    // expectations are the result of the previous rows' transfers.
    tbl[0]  = mk(2'b10, 0, 5'd0,  32'h0,    5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  2'b10, 0, 5'd0,  32'h0,        0, 0);
    tbl[1]  = mk(2'b00, 0, 5'd0,  32'h0,    5'd0,  32'h0,        5'd5,  5'd5,  2'b00, 1, 5'd5,  32'hDEADBEEF, 1, 1);
    tbl[2]  = mk(2'b00, 0, 5'd0,  32'h0,    5'd0,  32'h0,        5'd5,  5'd0,  2'b00, 0, 5'd5,  32'hDEADBEEF, 0, 0);
    tbl[3]  = mk(2'b11, 0, 5'd3,  32'h33,   5'd7,  32'h77,       5'd3,  5'd7,  2'b01, 0, 5'd5,  32'hDEADBEEF, 0, 0);
    tbl[4]  = mk(2'b11, 0, 5'd3,  32'h33,   5'd7,  32'h77,       5'd3,  5'd7,  2'b10, 1, 5'd3,  32'h33,       1, 0);
    tbl[5]  = mk(2'b11, 0, 5'd3,  32'h33,   5'd7,  32'h77,       5'd3,  5'd7,  2'b01, 1, 5'd7,  32'h77,       0, 1);
    tbl[6]  = mk(2'b11, 0, 5'd3,  32'h33,   5'd7,  32'h77,       5'd3,  5'd7,  2'b10, 1, 5'd3,  32'h33,       1, 0);
    tbl[7]  = mk(2'b01, 0, 5'd0,  32'h1234, 5'd7,  32'h77,       5'd0,  5'd7,  2'b01, 1, 5'd7,  32'h77,       0, 1);
    tbl[8]  = mk(2'b00, 0, 5'd0,  32'h0,    5'd0,  32'h0,        5'd0,  5'd0,  2'b00, 0, 5'd0,  32'h1234,     0, 0);
    tbl[9]  = mk(2'b01, 0, 5'd12, 32'hC,    5'd0,  32'h0,        5'd12, 5'd0,  2'b01, 0, 5'd0,  32'h1234,     0, 0);
    tbl[10] = mk(2'b10, 1, 5'd0,  32'h0,    5'd13, 32'hD,        5'd12, 5'd0,  2'b00, 1, 5'd12, 32'hC,        1, 0);
    tbl[11] = mk(2'b10, 1, 5'd0,  32'h0,    5'd13, 32'hD,        5'd12, 5'd0,  2'b00, 0, 5'd12, 32'hC,        0, 0);
    tbl[12] = mk(2'b10, 0, 5'd0,  32'h0,    5'd13, 32'hD,        5'd12, 5'd0,  2'b10, 0, 5'd12, 32'hC,        0, 0);
    tbl[13] = mk(2'b00, 0, 5'd0,  32'h0,    5'd0,  32'h0,        5'd13, 5'd13, 2'b00, 1, 5'd13, 32'hD,        1, 1);

    // Reset held two cycles with every requester valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_stage("rst_hold", 1'b0, 5'd0, 32'h0);
    chk("rst_hold_pend1", 32'(rs1_pend), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_stage("rst_after", 1'b0, 5'd0, 32'h0);
    chk("rst_first_grant", 32'(req_ready), 32'(2'b01));
    #1 req_valid = 2'b00;

    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      req_valid = tbl[i].vld;
      hold      = tbl[i].hld;
      req_addr  = {tbl[i].a1, tbl[i].a0};
      req_data  = {tbl[i].d1, tbl[i].d0};
      rs1_raddr = tbl[i].rs1;
      rs2_raddr = tbl[i].rs2;
      @(negedge clk);
      chk($sformatf("row%0d_rdy", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      chk_stage($sformatf("row%0d", i), tbl[i].e_wen, tbl[i].e_waddr, tbl[i].e_wdata);
      chk($sformatf("row%0d_pend1", i), 32'(rs1_pend), 32'(tbl[i].e_p1));
      chk($sformatf("row%0d_pend2", i), 32'(rs2_pend), 32'(tbl[i].e_p2));
    end

    // Reset mid-write: req0 accepted (pointer moves to 1), then reset drops the stage.
    @(posedge clk);
    #1;
    hold      = 1'b0;
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd9};
    req_data  = {32'h0, 32'h99};
    rs1_raddr = 5'd9;
    rs2_raddr = 5'd0;
    @(negedge clk);
    chk("midrst_accept_rdy", 32'(req_ready), 32'(2'b01));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst       = 1'b1;
    @(negedge clk);
    chk_stage("midrst_staged", 1'b1, 5'd9, 32'h99);
    chk("midrst_staged_pend1", 32'(rs1_pend), 32'd1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 2'b11;
    req_addr  = {5'd4, 5'd6};
    req_data  = {32'h44, 32'h66};
    @(negedge clk);
    chk_stage("midrst_dropped", 1'b0, 5'd0, 32'h0);
    chk("midrst_pend1", 32'(rs1_pend), 32'd0);
    chk("midrst_ptr0_rdy", 32'(req_ready), 32'(2'b01));

    // Back-to-back writes to one address: the later data is what the RF sees last.
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    req_addr  = {5'd6, 5'd6};
    req_data  = {32'hBB, 32'hAA};
    @(negedge clk);
    chk_stage("b2b_first", 1'b1, 5'd6, 32'h66);
    chk("b2b_rdy", 32'(req_ready), 32'(2'b10));
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    chk_stage("b2b_second", 1'b1, 5'd6, 32'hBB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
